// File: rtl/mult_div_pkg.sv
// mult_div_pkg: shared state encoding, opcode values and helpers for the
// signed multiply/divide controller.
package mult_div_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MULT = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } ctrlStateE;

  localparam logic       OP_MULT    = 1'b0;
  localparam logic       OP_DIV     = 1'b1;
  localparam int         ITER_COUNT = 32;
  localparam logic [5:0] LAST_ITER  = 6'(ITER_COUNT - 1);

  // Two's-complement magnitude; 0x80000000 maps to itself, which reads
  // correctly as the unsigned value 2^31.
  function automatic logic [31:0] absVal(input logic [31:0] v);
    return v[31] ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/mult_div_ctrl_if.sv
// mult_div_ctrl_if: request/result bundle between the control unit (master)
// and the multiply/divide controller (slave).
interface mult_div_ctrl_if;
  logic        start;
  logic        op;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        busy;
  logic        done;
  logic        hi_lo_write;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        div_zero;

  modport master (
    output start, op, a_in, b_in,
    input  busy, done, hi_lo_write, hi_out, lo_out, div_zero
  );

  modport slave (
    input  start, op, a_in, b_in,
    output busy, done, hi_lo_write, hi_out, lo_out, div_zero
  );
endinterface

// File: rtl/mult_div_ctrl_div_step.sv
// div_step: one restoring-division step on a {remainder, quotient} pair.
// The pair is shifted left by one, the divisor is trial-subtracted from the
// widened remainder, and the new quotient bit enters at the bottom.
module div_step (
  input  logic [63:0] remQuo,
  input  logic [31:0] divisor,
  output logic [63:0] nextRemQuo
);

  logic [32:0] remShiftS;
  logic [32:0] trialS;

  // Trial subtraction decides the quotient bit and the kept remainder.
  always_comb begin
    remShiftS = remQuo[63:31];
    trialS    = remShiftS - {1'b0, divisor};
    if (remShiftS >= {1'b0, divisor}) begin
      nextRemQuo = {trialS[31:0], remQuo[30:0], 1'b1};
    end else begin
      nextRemQuo = {remShiftS[31:0], remQuo[30:0], 1'b0};
    end
  end

endmodule

// File: rtl/mult_div_ctrl.sv
// mult_div_ctrl: iterative signed multiply (radix-2 Booth, 32 cycles) and
// signed divide (32 restoring steps on magnitudes plus one sign-fix cycle).
// Build option: MULTDIV_DIVZERO_TRAP_EN -- when defined, a divide by zero
// finishes in one cycle with a div_zero pulse and leaves Hi/Lo untouched.
module mult_div_ctrl
  import mult_div_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  mult_div_ctrl_if.slave bus
);

  ctrlStateE   stateR;
  logic [5:0]  cntR;
  logic [64:0] workR;      // MULT: {acc[32:0], multiplier}; DIV: {0, rem, quo}
  logic        qm1R;       // Booth q(-1) bit
  logic [32:0] mcandR;     // sign-extended multiplicand or divisor magnitude
  logic        aNegR;
  logic        qNegR;
  logic        bZeroR;
  logic        busyR;
  logic        doneR;
  logic        hiLoWriteR;
  logic        divZeroR;
  logic [31:0] hiR;
  logic [31:0] loR;

  logic        trapS;
  logic [32:0] boothSumS;
  logic [64:0] boothNextS;
  logic [63:0] divNextS;

  div_step uDivStep (
    .remQuo     (workR[63:0]),
    .divisor    (mcandR[31:0]),
    .nextRemQuo (divNextS)
  );

  // Flag requests that short-circuit as a divide-by-zero trap.
  always_comb begin
`ifdef MULTDIV_DIVZERO_TRAP_EN
    trapS = (bus.op == OP_DIV) && (bus.b_in == 32'd0);
`else
    trapS = 1'b0;
`endif
  end

  // Booth add/subtract followed by an arithmetic right shift of acc:Q:q-1.
  always_comb begin
    case ({workR[0], qm1R})
      2'b01:   boothSumS = workR[64:32] + mcandR;
      2'b10:   boothSumS = workR[64:32] - mcandR;
      default: boothSumS = workR[64:32];
    endcase
    boothNextS = {boothSumS[32], boothSumS, workR[31:1]};
  end

  // Controller FSM with registered strobes and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateR     <= ST_IDLE;
      cntR       <= 6'd0;
      workR      <= 65'd0;
      qm1R       <= 1'b0;
      mcandR     <= 33'd0;
      aNegR      <= 1'b0;
      qNegR      <= 1'b0;
      bZeroR     <= 1'b0;
      busyR      <= 1'b0;
      doneR      <= 1'b0;
      hiLoWriteR <= 1'b0;
      divZeroR   <= 1'b0;
      hiR        <= 32'd0;
      loR        <= 32'd0;
    end else begin
      case (stateR)
        ST_IDLE: begin
          doneR      <= 1'b0;
          hiLoWriteR <= 1'b0;
          divZeroR   <= 1'b0;
          cntR       <= 6'd0;
          if (bus.start) begin
            if (trapS) begin
              doneR    <= 1'b1;
              divZeroR <= 1'b1;
              stateR   <= ST_DONE;
            end else if (bus.op == OP_MULT) begin
              workR  <= {33'd0, bus.b_in};
              qm1R   <= 1'b0;
              mcandR <= {bus.a_in[31], bus.a_in};
              busyR  <= 1'b1;
              stateR <= ST_MULT;
            end else begin
              workR  <= {33'd0, absVal(bus.a_in)};
              mcandR <= {1'b0, absVal(bus.b_in)};
              aNegR  <= bus.a_in[31];
              qNegR  <= bus.a_in[31] ^ bus.b_in[31];
              bZeroR <= (bus.b_in == 32'd0);
              busyR  <= 1'b1;
              stateR <= ST_DIV;
            end
          end else begin
            stateR <= ST_IDLE;
          end
        end
        ST_MULT: begin
          workR <= boothNextS;
          qm1R  <= workR[0];
          if (cntR == LAST_ITER) begin
            hiR        <= boothNextS[63:32];
            loR        <= boothNextS[31:0];
            doneR      <= 1'b1;
            hiLoWriteR <= 1'b1;
            busyR      <= 1'b0;
            cntR       <= 6'd0;
            stateR     <= ST_DONE;
          end else begin
            cntR <= cntR + 6'd1;
          end
        end
        ST_DIV: begin
          workR <= {1'b0, divNextS};
          if (cntR == LAST_ITER) begin
            cntR   <= 6'd0;
            stateR <= ST_FIX;
          end else begin
            cntR <= cntR + 6'd1;
          end
        end
        ST_FIX: begin
          // Remainder follows the dividend sign; a zero divisor leaves the
          // all-ones quotient produced by the unconditional subtracts.
          hiR <= aNegR ? (32'd0 - workR[63:32]) : workR[63:32];
          if (bZeroR) begin
            loR <= 32'hFFFF_FFFF;
          end else begin
            loR <= qNegR ? (32'd0 - workR[31:0]) : workR[31:0];
          end
          doneR      <= 1'b1;
          hiLoWriteR <= 1'b1;
          busyR      <= 1'b0;
          stateR     <= ST_DONE;
        end
        ST_DONE: begin
          doneR      <= 1'b0;
          hiLoWriteR <= 1'b0;
          divZeroR   <= 1'b0;
          busyR      <= 1'b0;
          stateR     <= ST_IDLE;
        end
        default: begin
          doneR      <= 1'b0;
          hiLoWriteR <= 1'b0;
          divZeroR   <= 1'b0;
          busyR      <= 1'b0;
          cntR       <= 6'd0;
          stateR     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = busyR;
  assign bus.done        = doneR;
  assign bus.hi_lo_write = hiLoWriteR;
  assign bus.div_zero    = divZeroR;
  assign bus.hi_out      = hiR;
  assign bus.lo_out      = loR;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// tb_mult_div_ctrl: directed and random checks of mult_div_ctrl against an
// arithmetic reference model (signed product, truncating division).
module tb_mult_div_ctrl;
  import mult_div_pkg::*;

  logic clk;
  logic reset;
  int   nChecks;
  int   nErrors;
  logic [31:0] mdlHi;
  logic [31:0] mdlLo;

  mult_div_ctrl_if bus ();

  mult_div_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: expected Hi/Lo, latency in cycles after acceptance, trap flag.
  task automatic refModel(input logic opV, input logic [31:0] aV, input logic [31:0] bV,
                          output logic [31:0] eHi, output logic [31:0] eLo,
                          output int lat, output logic trap);
    longint sa, sb, prod, q, r;
    sa = longint'($signed(aV));
    sb = longint'($signed(bV));
    trap = 1'b0;
    if (opV == OP_MULT) begin
      prod = sa * sb;
      eHi = prod[63:32];
      eLo = prod[31:0];
      lat = 33;
    end else if (bV == 32'd0) begin
`ifdef MULTDIV_DIVZERO_TRAP_EN
      trap = 1'b1;
      eHi  = mdlHi;
      eLo  = mdlLo;
      lat  = 1;
`else
      eHi = aV;
      eLo = 32'hFFFF_FFFF;
      lat = 34;
`endif
    end else begin
      q = sa / sb;
      r = sa % sb;
      eHi = r[31:0];
      eLo = q[31:0];
      lat = 34;
    end
  endtask

  // Issue one request at the current negedge and watch it to completion.
  task automatic runOp(input string tag, input logic opV, input logic [31:0] aV,
                       input logic [31:0] bV, input int restartAt);
    logic [31:0] eHi, eLo, gotHi, gotLo;
    logic trap, gotHlw, gotDz, stable, busyOk, idleOk;
    int lat, k, doneCnt, doneAt;
    refModel(opV, aV, bV, eHi, eLo, lat, trap);
    stable = 1'b1; busyOk = 1'b1; idleOk = 1'b1;
    doneCnt = 0; doneAt = -1;
    gotHi = 32'd0; gotLo = 32'd0; gotHlw = 1'b0; gotDz = 1'b0;
    bus.start = 1'b1; bus.op = opV; bus.a_in = aV; bus.b_in = bV;
    @(negedge clk);
    k = 1;
    while (k <= lat + 3) begin
      if (bus.done) begin
        doneCnt++;
        if (doneCnt == 1) begin
          doneAt = k; gotHi = bus.hi_out; gotLo = bus.lo_out;
          gotHlw = bus.hi_lo_write; gotDz = bus.div_zero;
        end
      end else if (doneCnt == 0) begin
        if (bus.hi_out !== mdlHi || bus.lo_out !== mdlLo) stable = 1'b0;
        if (bus.busy !== ~trap || bus.hi_lo_write !== 1'b0) busyOk = 1'b0;
      end else begin
        if (bus.busy !== 1'b0 || bus.hi_lo_write !== 1'b0) idleOk = 1'b0;
      end
      bus.start = (k == restartAt);
      @(negedge clk);
      k++;
    end
    bus.start = 1'b0;
    checkVal({tag, "_latency"}, 64'(doneAt), 64'(lat));
    checkVal({tag, "_done_count"}, 64'(doneCnt), 64'd1);
    checkVal({tag, "_hi"}, {32'd0, gotHi}, {32'd0, eHi});
    checkVal({tag, "_lo"}, {32'd0, gotLo}, {32'd0, eLo});
    checkVal({tag, "_hlw"}, {63'd0, gotHlw}, {63'd0, ~trap});
    checkVal({tag, "_divzero"}, {63'd0, gotDz}, {63'd0, trap});
    checkVal({tag, "_hold_during_op"}, {63'd0, stable}, 64'd1);
    checkVal({tag, "_busy_during_op"}, {63'd0, busyOk}, 64'd1);
    checkVal({tag, "_idle_after"}, {63'd0, idleOk}, 64'd1);
    if (!trap) begin
      mdlHi = eHi;
      mdlLo = eLo;
    end
  endtask

  // Start a divide, pull reset mid-operation, and confirm a clean abort.
  task automatic abortDiv();
    logic seen;
    seen = 1'b0;
    bus.start = 1'b1; bus.op = OP_DIV; bus.a_in = 32'hFFFF_FFF9; bus.b_in = 32'd2;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    checkVal("abort_busy_before", {63'd0, bus.busy}, 64'd1);
    reset = 1'b0;
    #1;
    checkVal("abort_busy", {63'd0, bus.busy}, 64'd0);
    checkVal("abort_hi", {32'd0, bus.hi_out}, 64'd0);
    checkVal("abort_lo", {32'd0, bus.lo_out}, 64'd0);
    mdlHi = 32'd0;
    mdlLo = 32'd0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 2) reset = 1'b1;
      if (bus.done || bus.hi_lo_write || bus.busy) seen = 1'b1;
    end
    checkVal("abort_no_done", {63'd0, seen}, 64'd0);
  endtask

  initial begin
    logic        opR;
    logic [31:0] aR, bR;
    nChecks = 0; nErrors = 0;
    mdlHi = 32'd0; mdlLo = 32'd0;
    reset = 1'b0;
    bus.start = 1'b0; bus.op = OP_MULT; bus.a_in = 32'd0; bus.b_in = 32'd0;
    #1;
    checkVal("rst_busy", {63'd0, bus.busy}, 64'd0);
    checkVal("rst_done", {63'd0, bus.done}, 64'd0);
    checkVal("rst_hlw", {63'd0, bus.hi_lo_write}, 64'd0);
    checkVal("rst_divzero", {63'd0, bus.div_zero}, 64'd0);
    checkVal("rst_hi", {32'd0, bus.hi_out}, 64'd0);
    checkVal("rst_lo", {32'd0, bus.lo_out}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    runOp("mul_7_m3", OP_MULT, 32'd7, 32'hFFFF_FFFD, -1);
    runOp("mul_max", OP_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF, -1);
    runOp("mul_restart", OP_MULT, 32'h0001_2345, 32'hFFF0_0001, 5);
    runOp("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, -1);
    runOp("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    runOp("div_5_0", OP_DIV, 32'd5, 32'd0, -1);
    runOp("div_start_in_done", OP_DIV, 32'd100, 32'hFFFF_FFF9, 34);
    runOp("mul_minmin", OP_MULT, 32'h8000_0000, 32'h8000_0000, -1);
    abortDiv();
    runOp("mul_3_4", OP_MULT, 32'd3, 32'd4, -1);

    for (int n = 0; n < 24; n++) begin
      opR = 1'($urandom_range(0, 1));
      aR  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 9))
        0:       bR = 32'd0;
        1:       bR = 32'hFFFF_FFFF;
        2:       bR = 32'($urandom_range(1, 15));
        default: bR = 32'($urandom);
      endcase
      runOp(opR ? "rand_div" : "rand_mul", opR, aR, bR, -1);
    end

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule

// File: doc/mult_div_ctrl.md
MULT_DIV_CTRL -- requirements
Module: mult_div_ctrl

Interface
REQ-001 The module SHALL have one clock; reset is asynchronous and active-low.
REQ-002 clk  in  1  system clock, all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  one-cycle request from ctrl_unit; sampled only in IDLE.
REQ-005 op  in  1  0 = MULT (signed), 1 = DIV (signed); sampled with start.
REQ-006 a_in  in  32  operand from A register (multiplicand / dividend); sampled with start.
REQ-007 b_in  in  32  operand from B register (multiplier / divisor); sampled with start.
REQ-008 busy  out  1  high while an operation is in progress.
REQ-009 done  out  1  one-cycle completion pulse.
REQ-010 hi_lo_write  out  1  one-cycle write strobe for the Hi and Lo registers.
REQ-011 hi_out  out  32  Hi result.
REQ-012 lo_out  out  32  Lo result.
REQ-013 div_zero  out  1  one-cycle divide-by-zero exception pulse.

Function
REQ-014 States SHALL be IDLE, MULT, DIV, FIX and DONE; a 6-bit iteration counter SHALL run from 0 to 31.
REQ-015 IDLE, start=1 at edge T: operands SHALL be latched, busy SHALL be high from T+1, and the next state SHALL be MULT (op=0) or DIV (op=1).
REQ-016 MULT SHALL perform 32 radix-2 Booth iterations, one per cycle, then go to DONE; done and hi_lo_write SHALL be high in cycle T+33.
REQ-017 MULT result: {hi_out, lo_out} SHALL equal the signed 64-bit product a_in*b_in.
REQ-018 DIV SHALL perform 32 restoring steps on operand magnitudes, then take one FIX cycle for sign correction, then go to DONE; done and hi_lo_write SHALL be high in cycle T+34.
REQ-019 DIV result: lo_out SHALL be the quotient truncated toward zero, and hi_out SHALL be the remainder carrying the dividend's sign.
REQ-020 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo_out=0x80000000 and hi_out=0 (wrap, no exception).
REQ-021 DONE SHALL last one cycle, then return to IDLE with busy low in the same cycle as done.
REQ-022 hi_out and lo_out SHALL hold their last written values until the next completion; they SHALL not change during iterations.
REQ-023 start while busy or in DONE SHALL be ignored, with no queuing.
REQ-024 start in the same cycle that DONE returns to IDLE SHALL be ignored; start is accepted only when the current state is IDLE.

Reset
REQ-025 reset low SHALL force IDLE immediately, including mid-operation.
REQ-026 reset low SHALL clear the counter, busy, done, hi_lo_write and div_zero to 0, and hi_out and lo_out to 0x00000000.
REQ-027 An aborted operation SHALL produce no done pulse and no hi_lo_write pulse.

Configuration
REQ-028 The macro MULTDIV_DIVZERO_TRAP_EN SHALL select divide-by-zero handling.
REQ-029 With MULTDIV_DIVZERO_TRAP_EN defined, DIV with b_in=0 SHALL go IDLE -> DONE: done=1, div_zero=1 and hi_lo_write=0 in T+1, with hi_out and lo_out unchanged.
REQ-030 Without MULTDIV_DIVZERO_TRAP_EN, div_zero SHALL be tied 0; DIV with b_in=0 SHALL take normal latency (T+34) and write hi_out=a_in, lo_out=0xFFFFFFFF.

Structure
REQ-031 Package mult_div_pkg SHALL hold: the state enum, the op encodings OP_MULT=1'b0 and OP_DIV=1'b1, and ITER_COUNT=32.
REQ-032 One combinational sub-module, div_step (one restoring subtract/shift step on a 64-bit remainder:quotient pair), SHALL be instantiated by mult_div_ctrl.

Verification
REQ-033 MULT a=7, b=0xFFFFFFFD (-3) -> T+33: done=1, hi_lo_write=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy=0 at T+34.
REQ-034 MULT a=b=0x7FFFFFFF -> hi=0x3FFFFFFF, lo=0x00000001 at T+33.
REQ-035 DIV a=0xFFFFFFF9 (-7), b=2 -> T+34: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-036 DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0; DIV a=5, b=0 -> with macro: T+1 done=1, div_zero=1, hi/lo unchanged; without macro: T+34 hi=5, lo=0xFFFFFFFF.
REQ-037 Start MULT, then pulse start again at T+5 -> ignored, single done at T+33.
REQ-038 Reset low at T+10 of a DIV -> busy, hi and lo all 0 immediately, no done pulse; a new MULT 3*4 afterwards -> lo=12, hi=0.
